// File: rtl/fpm_exp_seq.sv
// Exponent-path sequencer for the FP multiplier.
// Shares one external 9-bit adder across three steps: exponent sum,
// normalization increment, bias removal. Flags zero/overflow/underflow.
module fpm_exp_seq #(
    parameter int unsigned BIAS = 127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] exp_a,
    input  logic [7:0] exp_b,
    input  logic       norm_inc,
    output logic [8:0] add_a,
    output logic [8:0] add_b,
    input  logic [8:0] add_s,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] exp_out,
    output logic       ovf,
    output logic       unf,
    output logic       zero
);

    localparam int unsigned EW = 8;
    localparam int unsigned AW = 9;

    // Adding 512-BIAS modulo 512 subtracts the bias.
    localparam logic [AW-1:0] BIAS_NEG = AW'(512 - BIAS);
    // Biased-sum limits, applied to the accumulator before bias removal.
    localparam logic [AW-1:0] OVF_LIM  = AW'(BIAS + 255);
    localparam logic [AW-1:0] UNF_LIM  = AW'(BIAS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD_E = 3'd1,
        ADD_N = 3'd2,
        SUB_B = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e        state_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] add_a_q;
    logic [AW-1:0] add_b_q;
    logic          n_q;
    logic          zero_flag_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [EW-1:0] exp_out_q;
    logic          ovf_q;
    logic          unf_q;
    logic          zero_q;

    // Sequencer: adder operands are loaded one cycle ahead so they are
    // stable for the whole step that consumes add_s.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            n_q         <= 1'b0;
            zero_flag_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            exp_out_q   <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        n_q         <= norm_inc;
                        zero_flag_q <= (exp_a == '0) || (exp_b == '0);
                        add_a_q     <= {1'b0, exp_a};
                        add_b_q     <= {1'b0, exp_b};
                        in_ready_q  <= 1'b0;
                        state_q     <= ADD_E;
                    end else begin
                        in_ready_q  <= 1'b1;
                    end
                end
                ADD_E: begin
                    acc_q   <= add_s;
                    add_a_q <= add_s;
                    add_b_q <= {{(AW-1){1'b0}}, n_q};
                    state_q <= ADD_N;
                end
                ADD_N: begin
                    acc_q   <= add_s;
                    add_a_q <= add_s;
                    add_b_q <= BIAS_NEG;
                    state_q <= SUB_B;
                end
                SUB_B: begin
                    add_a_q     <= '0;
                    add_b_q     <= '0;
                    out_valid_q <= 1'b1;
                    ovf_q       <= 1'b0;
                    unf_q       <= 1'b0;
                    zero_q      <= 1'b0;
                    if (zero_flag_q) begin
                        zero_q    <= 1'b1;
                        exp_out_q <= '0;
                    end else if (acc_q >= OVF_LIM) begin
                        ovf_q     <= 1'b1;
                        exp_out_q <= '1;
                    end else if (acc_q <= UNF_LIM) begin
                        unf_q     <= 1'b1;
                        exp_out_q <= '0;
                    end else begin
                        exp_out_q <= add_s[EW-1:0];
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_valid = out_valid_q;
    assign exp_out   = exp_out_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_fpm_exp_seq.sv
// Bench for fpm_exp_seq: directed vectors, scoreboard queue checked by a
// separate output monitor, plus in-flight checks of the adder drive.
module tb_fpm_exp_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       norm_inc;
    logic [8:0] add_a;
    logic [8:0] add_b;
    logic [8:0] add_s;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] exp_out;
    logic       ovf;
    logic       unf;
    logic       zero;

    int n_vec = 0;
    int n_err = 0;

    // expected {exp_out, ovf, unf, zero}
    logic [10:0] exp_q[$];

    fpm_exp_seq #(.BIAS(127)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .norm_inc  (norm_inc),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .ovf       (ovf),
        .unf       (unf),
        .zero      (zero)
    );

    // External shared adder, modulo 512.
    assign add_s = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Waits for in_ready, presents one operand pair for one cycle.
    // Returns at the falling edge inside the ADD_E cycle.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic n,
                         input logic push, input logic [7:0] e,
                         input logic o, input logic u, input logic z);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        exp_a    = a;
        exp_b    = b;
        norm_inc = n;
        if (push) exp_q.push_back({e, o, u, z});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits until the scoreboard has drained.
    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 16'(exp_q.size()), 16'd0);
        @(negedge clk);
    endtask

    // Output monitor: compares every accepted result against the queue head.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got exp_out=0x%0h ovf=%0b unf=%0b zero=%0b with nothing expected",
                             exp_out, ovf, unf, zero);
                end else begin
                    e = exp_q.pop_front();
                    check("result{exp,ovf,unf,zero}", 16'({exp_out, ovf, unf, zero}), 16'(e));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        logic [7:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        norm_inc  = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready",  16'(in_ready),  16'd0);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_add",       16'({add_a, add_b} != 0), 16'd0);
        check("rst_outputs",   16'({exp_out, ovf, unf, zero}), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 16'(in_ready), 16'd1);

        // 1: basic sum, latency and adder drive.
        issue(8'h80, 8'h81, 1'b0, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
        check("t1_add_a_adde", 16'(add_a), 16'h080);
        check("t1_add_b_adde", 16'(add_b), 16'h081);
        check("t1_in_ready_k1", 16'(in_ready), 16'd0);
        @(negedge clk);
        check("t1_add_b_addn", 16'(add_b), 16'h000);
        check("t1_in_ready_k2", 16'(in_ready), 16'd0);
        @(negedge clk);
        check("t1_add_b_subb", 16'(add_b), 16'h181);
        check("t1_out_valid_k3", 16'(out_valid), 16'd0);
        check("t1_in_ready_k3", 16'(in_ready), 16'd0);
        @(negedge clk);
        check("t1_out_valid_k4", 16'(out_valid), 16'd1);
        check("t1_in_ready_k4", 16'(in_ready), 16'd0);
        drain();

        // 2: normalization increment.
        issue(8'h80, 8'h80, 1'b1, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_add_a_addn", 16'(add_a), 16'h100);
        check("t2_add_b_addn", 16'(add_b), 16'h001);
        @(negedge clk);
        check("t2_add_a_subb", 16'(add_a), 16'h101);
        check("t2_add_b_subb", 16'(add_b), 16'h181);
        drain();

        // 3: overflow boundary.
        issue(8'hFE, 8'h7F, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        drain();
        issue(8'hFE, 8'h7F, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        drain();
        issue(8'hFE, 8'hFE, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        drain();

        // 4: underflow boundary.
        issue(8'h40, 8'h3F, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        drain();
        issue(8'h40, 8'h3F, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        drain();

        // 5: zero operands.
        issue(8'h00, 8'h90, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();
        issue(8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        // 6a: backpressure in DONE.
        out_ready = 1'b0;
        issue(8'h80, 8'h81, 1'b0, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t6_out_valid_wait", 16'(out_valid), 16'd1);
        held = exp_out;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_stall_valid",    16'(out_valid), 16'd1);
            check("t6_stall_exp",      16'(exp_out),   16'h82);
            check("t6_stall_hold",     16'(exp_out),   16'(held));
            check("t6_stall_in_ready", 16'(in_ready),  16'd0);
        end
        out_ready = 1'b1;
        drain();
        check("t6_in_ready_after", 16'(in_ready), 16'd1);

        // 6b: reset during SUB_B aborts the op.
        issue(8'hFE, 8'h7F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6b_in_subb", 16'(add_b), 16'h181);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6b_out_valid", 16'(out_valid), 16'd0);
        check("t6b_in_ready",  16'(in_ready),  16'd0);
        check("t6b_add",       16'({add_a, add_b}), 16'd0);
        check("t6b_outputs",   16'({exp_out, ovf, unf, zero}), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6b_in_ready_rel", 16'(in_ready), 16'd1);
        repeat (5) @(negedge clk);
        check("t6b_no_output", 16'(out_valid), 16'd0);
        issue(8'h80, 8'h81, 1'b0, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
        drain();

        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
